// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end: scan-code
// prefixes, special key indices, FSM state enums and the piano keymap.
package ps2_pkg;

    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [3:0] KEY_PLUS      = 4'd13;
    localparam logic [3:0] KEY_MINUS     = 4'd14;
    localparam logic [3:0] KEY_PIANO_MAX = 4'd12;

    typedef enum logic [1:0] {RxIdle, RxData, RxParity, RxStop} rx_state_e;
    typedef enum logic [1:0] {DecBase, DecExt, DecBrk, DecExtBrk} dec_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_lookup_t;

    // Scan code -> key index; hit=0 for codes outside the piano/select set.
    function automatic key_lookup_t ps2_keymap(input logic [7:0] code);
        key_lookup_t lk;
        lk.hit = 1'b1;
        lk.idx = 4'd0;
        case (code)
            8'h1A: lk.idx = 4'd0;
            8'h1B: lk.idx = 4'd1;
            8'h22: lk.idx = 4'd2;
            8'h21: lk.idx = 4'd3;
            8'h2B: lk.idx = 4'd4;
            8'h2A: lk.idx = 4'd5;
            8'h34: lk.idx = 4'd6;
            8'h32: lk.idx = 4'd7;
            8'h31: lk.idx = 4'd8;
            8'h3B: lk.idx = 4'd9;
            8'h3A: lk.idx = 4'd10;
            8'h42: lk.idx = 4'd11;
            8'h41: lk.idx = 4'd12;
            8'h55: lk.idx = KEY_PLUS;
            8'h4E: lk.idx = KEY_MINUS;
            default: lk.hit = 1'b0;
        endcase
        return lk;
    endfunction

endpackage

// File: rtl/ps2_kbd_poly_if.sv
// Bundle of PS/2 pins and keyboard outputs between the front end and its user.
interface ps2_kbd_poly_if #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SEL_W      = 2
);
    logic                    ps2_clk;
    logic                    ps2_dat;
    logic [14:0]             bitmask;
    logic [4*NUM_VOICES-1:0] voice_key;
    logic [NUM_VOICES-1:0]   voice_on;
    logic                    key_evt;
    logic [3:0]              key_evt_idx;
    logic                    key_evt_press;
    logic [SEL_W-1:0]        select;
    logic                    frame_err;

    modport master (
        output ps2_clk, ps2_dat,
        input  bitmask, voice_key, voice_on, key_evt, key_evt_idx, key_evt_press,
               select, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_dat,
        output bitmask, voice_key, voice_on, key_evt, key_evt_idx, key_evt_press,
               select, frame_err
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, 11-bit frame
// FSM and inactivity timeout. Optional odd-parity check under the
// PS2_PARITY_CHECK_EN macro; otherwise the parity bit is skipped.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       ar,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

    logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic             r_filt, r_filt_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             w_bit_en;
    rx_state_e        r_state, w_state_d;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             w_to_hit;
    logic             w_par_ok;
    logic             r_byte_valid, r_frame_err;
    logic [7:0]       r_byte_data;

    // Synchronize both pins; idle level is high.
    always_ff @(posedge clk) begin
        if (ar) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (ar) begin
            r_filt      <= 1'b1;
            r_filt_prev <= 1'b1;
            r_cnt       <= '0;
        end else begin
            r_filt_prev <= r_filt;
            if (r_clk_s2 != r_filt) begin
                if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
                    r_filt <= r_clk_s2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign w_bit_en = r_filt_prev & ~r_filt;

`ifdef PS2_PARITY_CHECK_EN
    logic r_par;
    assign w_par_ok = ^{r_par, r_shift};
`else
    assign w_par_ok = 1'b1;
`endif

    // Frame state register.
    always_ff @(posedge clk) begin
        if (ar) r_state <= RxIdle;
        else    r_state <= w_state_d;
    end

    // Frame next-state: advance per sampled bit, abandon on timeout.
    always_comb begin
        w_state_d = r_state;
        w_to_hit  = (r_state != RxIdle) && !w_bit_en &&
                    (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
        if (w_to_hit) begin
            w_state_d = RxIdle;
        end else if (w_bit_en) begin
            unique case (r_state)
                RxIdle:   if (!r_dat_s2) w_state_d = RxData;
                RxData:   if (r_bit_cnt == 3'd7) w_state_d = RxParity;
                RxParity: w_state_d = RxStop;
                RxStop:   w_state_d = RxIdle;
            endcase
        end
    end

    // Frame datapath: shift LSB first, check stop (and parity), count idle time.
    always_ff @(posedge clk) begin
        if (ar) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_to_cnt     <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_state == RxIdle || w_bit_en || w_to_hit) r_to_cnt <= '0;
            else                                            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_bit_en && !w_to_hit) begin
                case (r_state)
                    RxIdle: r_bit_cnt <= '0;
                    RxData: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
`ifdef PS2_PARITY_CHECK_EN
                    RxParity: r_par <= r_dat_s2;
`endif
                    RxStop: begin
                        if (r_dat_s2 && w_par_ok) begin
                            r_byte_valid <= 1'b1;
                            r_byte_data  <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;
    assign frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_kbd_poly.sv
// PS/2 keyboard front end for the wavetable synth: scan-code decoder,
// held-key bitmask, polyphonic voice allocator and wavetable select.
// Optional parity check in the receiver: define PS2_PARITY_CHECK_EN.
module ps2_kbd_poly
    import ps2_pkg::*;
#(
    parameter int unsigned NUM_VOICES  = 4,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned SEL_W       = 2
) (
    input logic              clk,
    input logic              ar,
    ps2_kbd_poly_if.slave    bus
);
    localparam int unsigned PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic        w_byte_valid;
    logic [7:0]  w_byte_data;
    logic        w_frame_err;

    dec_state_e  r_dec, w_dec_d;
    key_lookup_t w_lk;
    logic        w_evt, w_evt_press;
    logic [3:0]  w_evt_idx;

    logic [14:0]                     r_bitmask, w_bitmask_d;
    logic [NUM_VOICES-1:0][3:0]      r_voice_key, w_voice_key_d;
    logic [NUM_VOICES-1:0]           r_voice_on, w_voice_on_d;
    logic [PTR_W-1:0]                r_steal, w_steal_d;
    logic [PTR_W-1:0]                w_free_idx;
    logic                            w_free_found;
    logic [SEL_W-1:0]                r_select, w_select_d;
    logic                            r_key_evt, r_key_evt_press;
    logic [3:0]                      r_key_evt_idx;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .ar         (ar),
        .ps2_clk    (bus.ps2_clk),
        .ps2_dat    (bus.ps2_dat),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .frame_err  (w_frame_err)
    );

    // Decoder state register.
    always_ff @(posedge clk) begin
        if (ar) r_dec <= DecBase;
        else    r_dec <= w_dec_d;
    end

    // Decoder next-state and key event qualification.
    always_comb begin
        w_dec_d     = r_dec;
        w_evt       = 1'b0;
        w_evt_idx   = 4'd0;
        w_evt_press = 1'b0;
        w_lk        = ps2_keymap(w_byte_data);
        if (w_byte_valid) begin
            if (w_byte_data == PS2_BRK) begin
                w_dec_d = (r_dec == DecExt || r_dec == DecExtBrk) ? DecExtBrk : DecBrk;
            end else if (w_byte_data == PS2_EXT) begin
                w_dec_d = (r_dec == DecBrk || r_dec == DecExtBrk) ? DecExtBrk : DecExt;
            end else begin
                w_dec_d = DecBase;
                if (w_lk.hit && (r_dec == DecBase || r_dec == DecBrk)) begin
                    w_evt_press = (r_dec == DecBase);
                    w_evt_idx   = w_lk.idx;
                    // Typematic repeats and releases of unheld keys are dropped.
                    w_evt       = (w_evt_press != r_bitmask[w_lk.idx]);
                end
            end
        end
    end

    // Bitmask, select and voice allocation next-state.
    always_comb begin
        w_bitmask_d   = r_bitmask;
        w_select_d    = r_select;
        w_voice_on_d  = r_voice_on;
        w_voice_key_d = r_voice_key;
        w_steal_d     = r_steal;
        w_free_found  = 1'b0;
        w_free_idx    = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!r_voice_on[v] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = PTR_W'(v);
            end
        end
        if (w_evt) begin
            w_bitmask_d[w_evt_idx] = w_evt_press;
            if (w_evt_press && w_evt_idx == KEY_PLUS)  w_select_d = r_select + SEL_W'(1);
            if (w_evt_press && w_evt_idx == KEY_MINUS) w_select_d = r_select - SEL_W'(1);
            if (w_evt_idx <= KEY_PIANO_MAX) begin
                if (w_evt_press) begin
                    if (w_free_found) begin
                        w_voice_on_d[w_free_idx]  = 1'b1;
                        w_voice_key_d[w_free_idx] = w_evt_idx;
                    end else begin
                        w_voice_key_d[r_steal] = w_evt_idx;
                        w_steal_d = (r_steal == PTR_W'(NUM_VOICES - 1)) ? '0
                                                                         : r_steal + PTR_W'(1);
                    end
                end else begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (r_voice_on[v] && r_voice_key[v] == w_evt_idx) begin
                            w_voice_on_d[v] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Output-side state; key_evt is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (ar) begin
            r_bitmask       <= '0;
            r_select        <= '0;
            r_voice_on      <= '0;
            r_voice_key     <= '0;
            r_steal         <= '0;
            r_key_evt       <= 1'b0;
            r_key_evt_idx   <= '0;
            r_key_evt_press <= 1'b0;
        end else begin
            r_bitmask       <= w_bitmask_d;
            r_select        <= w_select_d;
            r_voice_on      <= w_voice_on_d;
            r_voice_key     <= w_voice_key_d;
            r_steal         <= w_steal_d;
            r_key_evt       <= w_evt;
            r_key_evt_idx   <= w_evt_idx;
            r_key_evt_press <= w_evt_press;
        end
    end

    assign bus.bitmask       = r_bitmask;
    assign bus.voice_key     = r_voice_key;
    assign bus.voice_on      = r_voice_on;
    assign bus.key_evt       = r_key_evt;
    assign bus.key_evt_idx   = r_key_evt_idx;
    assign bus.key_evt_press = r_key_evt_press;
    assign bus.select        = r_select;
    assign bus.frame_err     = w_frame_err;

endmodule

// File: tb/tb_ps2_kbd_poly.sv
// Scoreboard bench for ps2_kbd_poly: stimulus pushes expected key events and
// frame errors; a monitor pops and compares whenever the DUT strobes.
module tb_ps2_kbd_poly;
    localparam int unsigned NV      = 4;
    localparam int unsigned SW      = 2;
    localparam int unsigned TO      = 400;
    localparam int unsigned HALF    = 20;

    typedef struct packed {
        logic       err;
        logic [3:0] idx;
        logic       press;
    } exp_t;

    logic clk = 1'b0;
    logic ar  = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    ps2_kbd_poly_if #(.NUM_VOICES(NV), .SEL_W(SW)) bus ();

    ps2_kbd_poly #(
        .NUM_VOICES  (NV),
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TO),
        .SEL_W       (SW)
    ) dut (
        .clk (clk),
        .ar  (ar),
        .bus (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!ar && (bus.key_evt || bus.frame_err)) begin
            exp_t obs;
            obs.err   = bus.frame_err;
            obs.idx   = bus.key_evt ? bus.key_evt_idx : 4'd0;
            obs.press = bus.key_evt ? bus.key_evt_press : 1'b0;
            if (q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_event: got %0h want none", obs);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("event", 32'(obs), 32'(e));
            end
        end
    end

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_dat = bits[i];
            repeat (HALF) @(posedge clk);
            #1 bus.ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            #1 bus.ps2_clk = 1'b1;
        end
        bus.ps2_dat = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bits({~bad_stop, par, b, 1'b0}, 11);
        repeat (HALF) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic key(input logic [7:0] b);
        send(b, 1'b0, 1'b0);
    endtask

    task automatic exp_evt(input logic [3:0] idx, input logic press);
        q.push_back('{err: 1'b0, idx: idx, press: press});
    endtask

    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        repeat (4) @(posedge clk);
        #1 ar = 1'b0;
        @(negedge clk);
        check("rst_bitmask", 32'(bus.bitmask), 32'h0);
        check("rst_voice_on", 32'(bus.voice_on), 32'h0);
        check("rst_voice_key", 32'(bus.voice_key), 32'h0);
        check("rst_select", 32'(bus.select), 32'h0);
        check("rst_strobes", {30'd0, bus.key_evt, bus.frame_err}, 32'h0);

        // Press/release Z, with a typematic repeat and a stray release.
        exp_evt(4'd0, 1'b1);
        key(8'h1A);
        check("z_bitmask", 32'(bus.bitmask), 32'h1);
        check("z_voice_on", 32'(bus.voice_on), 32'h1);
        check("z_voice_key", 32'(bus.voice_key), 32'h0);
        key(8'h1A);
        check("z_repeat", 32'(bus.bitmask), 32'h1);
        exp_evt(4'd0, 1'b0);
        key(8'hF0); key(8'h1A);
        check("z_rel_bitmask", 32'(bus.bitmask), 32'h0);
        check("z_rel_voice_on", 32'(bus.voice_on), 32'h0);
        key(8'hF0); key(8'h1A);

        // Polyphony: five presses on four voices, then a sixth.
        exp_evt(4'd0, 1'b1); key(8'h1A);
        exp_evt(4'd1, 1'b1); key(8'h1B);
        exp_evt(4'd2, 1'b1); key(8'h22);
        exp_evt(4'd3, 1'b1); key(8'h21);
        exp_evt(4'd4, 1'b1); key(8'h2B);
        check("poly_voice_key", 32'(bus.voice_key), 32'h3214);
        check("poly_voice_on", 32'(bus.voice_on), 32'hF);
        exp_evt(4'd5, 1'b1); key(8'h2A);
        check("steal2_voice_key", 32'(bus.voice_key), 32'h3254);
        check("poly_bitmask", 32'(bus.bitmask), 32'h3F);
        exp_evt(4'd1, 1'b0); key(8'hF0); key(8'h1B);
        check("stolen_rel_on", 32'(bus.voice_on), 32'hF);
        exp_evt(4'd0, 1'b0); key(8'hF0); key(8'h1A);
        exp_evt(4'd2, 1'b0); key(8'hF0); key(8'h22);
        check("rel2_on", 32'(bus.voice_on), 32'hB);
        exp_evt(4'd3, 1'b0); key(8'hF0); key(8'h21);
        exp_evt(4'd4, 1'b0); key(8'hF0); key(8'h2B);
        check("rel4_on", 32'(bus.voice_on), 32'h2);
        exp_evt(4'd5, 1'b0); key(8'hF0); key(8'h2A);
        check("all_rel_on", 32'(bus.voice_on), 32'h0);
        check("all_rel_bitmask", 32'(bus.bitmask), 32'h0);

        // Wavetable select wraps both ways.
        exp_evt(4'd14, 1'b1); key(8'h4E);
        check("sel_minus", 32'(bus.select), 32'h3);
        exp_evt(4'd14, 1'b0); key(8'hF0); key(8'h4E);
        exp_evt(4'd13, 1'b1); key(8'h55);
        check("sel_plus1", 32'(bus.select), 32'h0);
        exp_evt(4'd13, 1'b0); key(8'hF0); key(8'h55);
        exp_evt(4'd13, 1'b1); key(8'h55);
        check("sel_plus2", 32'(bus.select), 32'h1);
        exp_evt(4'd13, 1'b0); key(8'hF0); key(8'h55);
        check("sel_voice_on", 32'(bus.voice_on), 32'h0);

        // Extended codes never act as keys.
        key(8'hE0); key(8'h1A);
        check("ext_bitmask", 32'(bus.bitmask), 32'h0);
        exp_evt(4'd0, 1'b1); key(8'h1A);
        key(8'hE0); key(8'hF0); key(8'h1A);
        check("ext_brk_bitmask", 32'(bus.bitmask), 32'h1);
        exp_evt(4'd0, 1'b0); key(8'hF0); key(8'h1A);

        // Bad stop bit drops the byte.
        q.push_back('{err: 1'b1, idx: 4'd0, press: 1'b0});
        send(8'h1A, 1'b0, 1'b1);
        check("stop_err_bitmask", 32'(bus.bitmask), 32'h0);

        // Bad parity: dropped only when the check is built in.
`ifdef PS2_PARITY_CHECK_EN
        q.push_back('{err: 1'b1, idx: 4'd0, press: 1'b0});
        send(8'h1A, 1'b1, 1'b0);
        check("par_err_bitmask", 32'(bus.bitmask), 32'h0);
`else
        exp_evt(4'd0, 1'b1);
        send(8'h1A, 1'b1, 1'b0);
        check("par_ign_bitmask", 32'(bus.bitmask), 32'h1);
        exp_evt(4'd0, 1'b0); key(8'hF0); key(8'h1A);
`endif

        // Unmapped code is ignored.
        key(8'h1C); key(8'hF0); key(8'h1C);
        check("unmapped_bitmask", 32'(bus.bitmask), 32'h0);

        // Partial frame abandoned by timeout; next frame decodes cleanly.
        send_bits({1'b1, 1'b0, 8'h1B, 1'b0}, 5);
        repeat (TO + 100) @(posedge clk);
        exp_evt(4'd1, 1'b1); key(8'h1B);
        check("timeout_bitmask", 32'(bus.bitmask), 32'h2);
        check("timeout_voice_key", 32'(bus.voice_key[3:0]), 32'h1);

        // Reset clears all held state.
        #1 ar = 1'b1;
        repeat (2) @(posedge clk);
        #1 ar = 1'b0;
        @(negedge clk);
        check("rst2_bitmask", 32'(bus.bitmask), 32'h0);
        check("rst2_voice_on", 32'(bus.voice_on), 32'h0);
        check("rst2_select", 32'(bus.select), 32'h0);

        repeat (10) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
